fp_add_initiator: RTL

FP_ADD_INITIATOR -- requirements
Module: fp_add_initiator

---
 rtl/fp_add_initiator.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/fp_add_initiator.sv
// fp_add_initiator: queues IEEE-754 single operand pairs and sequences them
// one at a time through an external adder (IDLE -> ISSUE -> WAIT -> HOLD).
// Optional feature: define FP_ADD_TIMEOUT_EN to abort a WAIT that exceeds
// TIMEOUT_CYCLES, returning a quiet NaN with res_error set.
module fp_add_initiator #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_available,
  output logic        add_exception,
  input  logic [31:0] add_sum,
  input  logic        add_done,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_sum,
  output logic        res_error,
  output logic        busy
);

  localparam int              PW   = $clog2(DEPTH);
  localparam int              CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]   FULL = CW'(DEPTH);

  // Elaboration-time guard on the parameter ranges this block supports.
  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1)
  begin : g_bad_param
    $error("fp_add_initiator: DEPTH must be a power of two in 2..16, TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_e;

  function automatic logic is_special(input logic [31:0] x);
    return x[30:23] == 8'hFF;
  endfunction

  state_e          state_q, state_d;
  logic [63:0]     mem [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     add_a_q, add_a_d, add_b_q, add_b_d;
  logic            add_exc_q, add_exc_d;
  logic [31:0]     res_sum_q, res_sum_d;
  logic [63:0]     head;
  logic            push, pop;

`ifdef FP_ADD_TIMEOUT_EN
  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]   QNAN     = 32'h7FC0_0000;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          res_err_q, res_err_d;
  assign res_error = res_err_q;
`else
  assign res_error = 1'b0;
`endif

  // in_ready depends only on the registered occupancy, never on this cycle's pop.
  assign in_ready      = (count_q != FULL);
  assign push          = in_valid && in_ready;
  assign pop           = (state_q == S_IDLE) && (count_q != '0);
  assign head          = mem[rd_ptr_q];
  assign add_a         = add_a_q;
  assign add_b         = add_b_q;
  assign add_exception = add_exc_q;
  assign add_available = (state_q == S_ISSUE);
  assign res_valid     = (state_q == S_HOLD);
  assign res_sum       = res_sum_q;
  assign busy          = (state_q != S_IDLE);

  // Next-state logic for the queue pointers, occupancy and operation sequencer.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q + PW'(push);
    rd_ptr_d  = rd_ptr_q + PW'(pop);
    count_d   = count_q;
    add_a_d   = add_a_q;
    add_b_d   = add_b_q;
    add_exc_d = add_exc_q;
    res_sum_d = res_sum_q;
`ifdef FP_ADD_TIMEOUT_EN
    tmo_d     = '0;
    res_err_d = res_err_q;
`endif

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          add_a_d   = head[63:32];
          add_b_d   = head[31:0];
          add_exc_d = is_special(head[63:32]) || is_special(head[31:0]);
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        // A completion on the expiry cycle takes priority over the abort.
        if (add_done) begin
          res_sum_d = add_sum;
`ifdef FP_ADD_TIMEOUT_EN
          res_err_d = 1'b0;
`endif
          state_d   = S_HOLD;
        end
`ifdef FP_ADD_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          res_sum_d = QNAN;
          res_err_d = 1'b1;
          state_d   = S_HOLD;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      S_HOLD: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand storage; written on push only.
  // NOTE: the array has no reset -- the pointers and occupancy define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {in_a, in_b};
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      add_a_q   <= '0;
      add_b_q   <= '0;
      add_exc_q <= 1'b0;
      res_sum_q <= '0;
`ifdef FP_ADD_TIMEOUT_EN
      tmo_q     <= '0;
      res_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
      add_exc_q <= add_exc_d;
      res_sum_q <= res_sum_d;
`ifdef FP_ADD_TIMEOUT_EN
      tmo_q     <= tmo_d;
      res_err_q <= res_err_d;
`endif
    end
  end

endmodule
